// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter: state encoding, default bit period, frame length.
// UART_RX_PARITY_EN adds the PARITY state and lengthens the frame by one bit.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int DATA_BITS        = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS       = 11;
`else
    localparam int FRAME_BITS       = 10;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY  = 3'd3,
`endif
        ST_STOP    = 3'd4,
        ST_CLEANUP = 3'd5
    } uart_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/receiver_if.sv
// Serial line in, byte/strobe outputs of the UART receiver.
// master = receiver side, slave = consumer (command FSM / bench) side.
interface receiver_if;

    logic       i_Serial_Data;
    logic       o_DV;
    logic [7:0] o_Byte;
    logic       o_Sig_Active;
    logic       o_Frame_Err;
    logic       o_Parity_Err;

    modport master (
        input  i_Serial_Data,
        output o_DV,
        output o_Byte,
        output o_Sig_Active,
        output o_Frame_Err,
        output o_Parity_Err
    );

    modport slave (
        output i_Serial_Data,
        input  o_DV,
        input  o_Byte,
        input  o_Sig_Active,
        input  o_Frame_Err,
        input  o_Parity_Err
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; 2-cycle latency, no backpressure.
// Both stages reset to 1 so reset never looks like a start bit.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/receiver.sv
// UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN): mid-bit sampling, byte valid CLKS_PER_BIT/2+9*CLKS_PER_BIT
// cycles after start detection (+CLKS_PER_BIT with parity); no backpressure, o_DV is a one-cycle pulse.
module receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    receiver_if.master rx
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  MID_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           byte_q, byte_d;
    logic                 dv_q, dv_d;
    logic                 active_q, active_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 par_bad_q, par_bad_d;
`endif

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx.i_Serial_Data),
        .q     (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        active_d  = active_q;
        dv_d      = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == MID_END) begin
                    cnt_d = '0;
                    // A start bit that is gone by mid-bit was noise; drop it silently.
                    if (!rx_s) begin
                        state_d  = ST_DATA;
                        active_d = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_s != even_parity(shift_q));
                    perr_d    = par_bad_d;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = ST_CLEANUP;
`ifdef UART_RX_PARITY_EN
                    // A frame already flagged for parity reports nothing else.
                    if (!par_bad_q) begin
`else
                    begin
`endif
                        if (rx_s) begin
                            byte_d = shift_q;
                            dv_d   = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CLEANUP: begin
                active_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            active_q  <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            active_q  <= active_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign rx.o_DV         = dv_q;
    assign rx.o_Byte       = byte_q;
    assign rx.o_Sig_Active = active_q;
    assign rx.o_Frame_Err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx.o_Parity_Err = perr_q;
`else
    assign rx.o_Parity_Err = 1'b0;
`endif

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set the clock cycles per UART bit period (100 MHz clock, 115200 baud); legal values are 4 and above.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 i_Serial_Data  input  1  SHALL be the asynchronous UART line, idle high, 8N1 framing (8E1 with parity enabled).
REQ-005 o_DV  output  1  SHALL be a one-cycle pulse marking a valid received byte; it drives the command FSM control_in.
REQ-006 o_Byte  output  8  SHALL hold the last valid byte; it drives the command FSM data_in.
REQ-007 o_Sig_Active  output  1  SHALL be high from start-bit confirmation until return to IDLE.
REQ-008 o_Frame_Err  output  1  SHALL be a one-cycle pulse on a bad stop bit.
REQ-009 o_Parity_Err  output  1  SHALL be a one-cycle pulse on a parity mismatch.

Function
REQ-010 i_Serial_Data SHALL pass through a 2-flop synchronizer, reset to 1, before any use.
REQ-011 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and CLEANUP, with a bit counter 0..CLKS_PER_BIT-1 and a bit index 0..7.
REQ-012 IDLE SHALL move to START on a synchronized low and clear the counter.
REQ-013 START SHALL resample at count CLKS_PER_BIT/2-1: low goes to DATA with o_Sig_Active=1; high (glitch) goes back to IDLE with no output pulse.
REQ-014 DATA SHALL sample one bit every CLKS_PER_BIT cycles, LSB first, into a shift register; after index 7 it goes to PARITY (if enabled) or STOP.
REQ-015 STOP SHALL sample after CLKS_PER_BIT cycles: a high sample updates o_Byte and pulses o_DV; a low sample pulses o_Frame_Err and leaves o_Byte unchanged.
REQ-016 With no errors, o_DV SHALL assert exactly CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first synchronized low (plus CLKS_PER_BIT with parity).
REQ-017 CLEANUP SHALL last one cycle, clear o_Sig_Active and return to IDLE.
REQ-018 A low line seen in the IDLE cycle after CLEANUP SHALL start a new frame, so back-to-back frames are received without loss.
REQ-019 At most one of o_DV, o_Frame_Err and o_Parity_Err SHALL assert per frame.
REQ-020 A line held permanently low SHALL produce one o_Frame_Err per 10-bit period and never o_DV.

Reset
REQ-021 Reset SHALL force IDLE, counter=0, index=0, shift register=0, o_Byte=0, o_DV=0, o_Sig_Active=0, o_Frame_Err=0, o_Parity_Err=0, and synchronizer flops=1.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no pulse; reception resumes on the next start bit after release.

Configuration
REQ-023 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL sample one even-parity bit; on a mismatch it pulses o_Parity_Err, suppresses o_DV and still checks timing through STOP.
REQ-024 Without UART_RX_PARITY_EN, the PARITY state SHALL be removed, DATA goes directly to STOP, and o_Parity_Err is tied to 0.

Structure
REQ-025 A shared package uart_pkg SHALL hold the state enum type, the default CLKS_PER_BIT constant and the frame-length constant; the transmitter imports the same package.
REQ-026 The synchronizer SHALL be the sub-module sync_2ff; there are no other sub-modules.

Verification (bench CLKS_PER_BIT=8)
REQ-027 Frame 0x01 -> one o_DV pulse, o_Byte=0x01, exactly 76 cycles after the first synchronized low (84 with parity).
REQ-028 Back-to-back frames 0x00,0x01,0x08,0x09,0x10,0x11,0x18,0x19 (no idle gap) -> eight o_DV pulses in order, with no o_Frame_Err.
REQ-029 Line low for 2 cycles then high -> no o_DV, o_Sig_Active returns to 0, and a following frame 0x65 is received correctly.
REQ-030 Frame 0x77 with stop bit 0 -> one o_Frame_Err pulse, no o_DV, o_Byte keeps its prior value 0x65.
REQ-031 With UART_RX_PARITY_EN, 0x68 sent with odd parity -> one o_Parity_Err pulse and no o_DV; 0x68 with correct parity 1 -> o_DV with o_Byte=0x68.
REQ-032 Reset pulsed during bit 4 of 0x65 -> all outputs 0 and no pulse; the next frame 0x65 -> o_DV with o_Byte=0x65.
